// File: rtl/temp_mon_pkg.sv
// Shared types and constants for the temperature window monitor.
// State encoding is fixed so mon_state can be decoded by downstream logic.
package temp_mon_pkg;

   typedef enum logic [2:0] {
      ST_NORMAL    = 3'd0,
      ST_PEND_LOW  = 3'd1,
      ST_LOW       = 3'd2,
      ST_PEND_HIGH = 3'd3,
      ST_HIGH      = 3'd4
   } mon_state_t;

   localparam logic [7:0] TEMP_LOW_DEFAULT  = 8'h23;
   localparam logic [7:0] TEMP_HIGH_DEFAULT = 8'h27;

   function automatic logic is_alarm(input mon_state_t s);
      return (s == ST_LOW) || (s == ST_HIGH);
   endfunction

endpackage

// File: rtl/temp_window_cmp.sv
// Combinational threshold comparator with saturating hysteresis margins.
// Margins use one extra bit so low+HYST and high-HYST cannot wrap.
module temp_window_cmp #(
   parameter int WIDTH = 8,
   parameter int HYST  = 1
) (
   input  logic [WIDTH-1:0] t,
   input  logic [WIDTH-1:0] low,
   input  logic [WIDTH-1:0] high,
   output logic             below_low,
   output logic             above_high,
   output logic             exit_low,
   output logic             exit_high
);

   localparam logic [WIDTH:0] HYST_W = (WIDTH+1)'(HYST);
   localparam logic [WIDTH:0] MAX_W  = {1'b0, {WIDTH{1'b1}}};

   logic [WIDTH:0] t_w;
   logic [WIDTH:0] low_sum;
   logic [WIDTH:0] low_margin;
   logic [WIDTH:0] high_margin;

   assign t_w         = {1'b0, t};
   assign low_sum     = {1'b0, low} + HYST_W;
   assign low_margin  = (low_sum > MAX_W) ? MAX_W : low_sum;
   assign high_margin = ({1'b0, high} < HYST_W) ? '0 : ({1'b0, high} - HYST_W);

   assign below_low  = (t < low);
   assign above_high = (t > high);
   assign exit_low   = (t_w >= low_margin);
   assign exit_high  = (t_w <= high_margin);

endmodule

// File: rtl/temp_window_monitor.sv
// Debounced temperature window monitor: programmable thresholds, excursion
// debounce, hysteretic exit, sticky alarm and config-rejection pulse.
module temp_window_monitor
   import temp_mon_pkg::*;
#(
   parameter int                WIDTH     = 8,
   parameter logic [WIDTH-1:0]  LOW_INIT  = WIDTH'(TEMP_LOW_DEFAULT),
   parameter logic [WIDTH-1:0]  HIGH_INIT = WIDTH'(TEMP_HIGH_DEFAULT),
   parameter int                HYST      = 1,
   parameter int                DEBOUNCE  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] temperature,
   input  logic             cfg_we,
   input  logic [WIDTH-1:0] cfg_low,
   input  logic [WIDTH-1:0] cfg_high,
   input  logic             alarm_clear,
   output logic             low_abn,
   output logic             high_abn,
   output logic             alarm_sticky,
   output logic             cfg_error,
   output logic [2:0]       mon_state
);

   localparam int             CW    = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0]  ONE   = CW'(1);
   localparam logic [CW-1:0]  DEB_C = CW'(DEBOUNCE);
   localparam mon_state_t     ENTRY_LOW  = (DEBOUNCE == 1) ? ST_LOW  : ST_PEND_LOW;
   localparam mon_state_t     ENTRY_HIGH = (DEBOUNCE == 1) ? ST_HIGH : ST_PEND_HIGH;

   mon_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] low_q, low_d, high_q, high_d;
   logic             low_abn_q, high_abn_q, sticky_q, sticky_d, cfg_err_q;
   logic             below_low, above_high, exit_low, exit_high;
   logic             cfg_ok;

   temp_window_cmp #(.WIDTH(WIDTH), .HYST(HYST)) u_cmp (
      .t          (temperature),
      .low        (low_q),
      .high       (high_q),
      .below_low  (below_low),
      .above_high (above_high),
      .exit_low   (exit_low),
      .exit_high  (exit_high)
   );

   assign cfg_ok = cfg_low < cfg_high;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      low_d   = low_q;
      high_d  = high_q;
      // A config write always consumes the cycle, so a coincident sample is dropped.
      if (cfg_we) begin
         if (cfg_ok) begin
            low_d   = cfg_low;
            high_d  = cfg_high;
            state_d = ST_NORMAL;
            cnt_d   = '0;
         end
      end else if (sample_valid) begin
         case (state_q)
            ST_NORMAL: begin
               if (below_low)       begin state_d = ENTRY_LOW;  cnt_d = ONE; end
               else if (above_high) begin state_d = ENTRY_HIGH; cnt_d = ONE; end
            end
            ST_PEND_LOW: begin
               if (below_low) begin
                  if (cnt_q >= DEB_C - ONE) begin state_d = ST_LOW; cnt_d = DEB_C; end
                  else                              cnt_d = cnt_q + ONE;
               end else if (above_high) begin state_d = ENTRY_HIGH; cnt_d = ONE; end
               else                     begin state_d = ST_NORMAL;  cnt_d = '0;  end
            end
            ST_PEND_HIGH: begin
               if (above_high) begin
                  if (cnt_q >= DEB_C - ONE) begin state_d = ST_HIGH; cnt_d = DEB_C; end
                  else                               cnt_d = cnt_q + ONE;
               end else if (below_low) begin state_d = ENTRY_LOW; cnt_d = ONE; end
               else                    begin state_d = ST_NORMAL; cnt_d = '0;  end
            end
            ST_LOW: begin
               if (above_high)    begin state_d = ENTRY_HIGH; cnt_d = ONE; end
               else if (exit_low) begin state_d = ST_NORMAL;  cnt_d = '0;  end
            end
            ST_HIGH: begin
               if (below_low)      begin state_d = ENTRY_LOW; cnt_d = ONE; end
               else if (exit_high) begin state_d = ST_NORMAL; cnt_d = '0;  end
            end
            default: begin state_d = ST_NORMAL; cnt_d = '0; end
         endcase
      end
   end

   // Entering an alarm state beats a simultaneous clear.
   always_comb begin
      sticky_d = sticky_q;
      if (is_alarm(state_d) && (state_d != state_q)) sticky_d = 1'b1;
      else if (alarm_clear)                          sticky_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_NORMAL;
         cnt_q      <= '0;
         low_q      <= LOW_INIT;
         high_q     <= HIGH_INIT;
         low_abn_q  <= 1'b0;
         high_abn_q <= 1'b0;
         sticky_q   <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         low_q      <= low_d;
         high_q     <= high_d;
         low_abn_q  <= (state_d == ST_LOW);
         high_abn_q <= (state_d == ST_HIGH);
         sticky_q   <= sticky_d;
         cfg_err_q  <= cfg_we && !cfg_ok;
      end
   end

   assign low_abn      = low_abn_q;
   assign high_abn     = high_abn_q;
   assign alarm_sticky = sticky_q;
   assign cfg_error    = cfg_err_q;
   assign mon_state    = state_q;

endmodule

// File: tb/tb_temp_window_monitor.sv
// Scoreboard bench for temp_window_monitor: directed samples with hand-computed
// expected outputs queued per cycle and checked by an independent monitor.
module tb_temp_window_monitor;

   localparam logic [2:0] SN  = 3'd0;
   localparam logic [2:0] SPL = 3'd1;
   localparam logic [2:0] SL  = 3'd2;
   localparam logic [2:0] SPH = 3'd3;
   localparam logic [2:0] SH  = 3'd4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sample_valid = 1'b0;
   logic [7:0] temperature = '0;
   logic       cfg_we = 1'b0;
   logic [7:0] cfg_low = '0;
   logic [7:0] cfg_high = '0;
   logic       alarm_clear = 1'b0;
   logic       low_abn, high_abn, alarm_sticky, cfg_error;
   logic [2:0] mon_state;

   int checks = 0;
   int failures = 0;

   // Packed expectation: {state[2:0], low_abn, high_abn, sticky, cfg_error}
   logic [6:0] exp_q[$];
   string      name_q[$];

   temp_window_monitor dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .temperature  (temperature),
      .cfg_we       (cfg_we),
      .cfg_low      (cfg_low),
      .cfg_high     (cfg_high),
      .alarm_clear  (alarm_clear),
      .low_abn      (low_abn),
      .high_abn     (high_abn),
      .alarm_sticky (alarm_sticky),
      .cfg_error    (cfg_error),
      .mon_state    (mon_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [6:0] got, input logic [6:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s: got state=%0d low=%0b high=%0b sticky=%0b cfgerr=%0b, expected state=%0d low=%0b high=%0b sticky=%0b cfgerr=%0b",
                  name, got[6:4], got[3], got[2], got[1], got[0],
                  expv[6:4], expv[3], expv[2], expv[1], expv[0]);
      end else begin
         $display("ok   %s: state=%0d low=%0b high=%0b sticky=%0b cfgerr=%0b",
                  name, got[6:4], got[3], got[2], got[1], got[0]);
      end
   endtask

   // Monitor: outputs are registered, so each cycle's result is visible just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            check(name_q.pop_front(),
                  {mon_state, low_abn, high_abn, alarm_sticky, cfg_error},
                  exp_q.pop_front());
         end
      end
   end

   task automatic step(input bit v, input logic [7:0] t, input bit we,
                       input logic [7:0] lo, input logic [7:0] hi, input bit clr,
                       input logic [2:0] es, input bit el, input bit eh,
                       input bit est, input bit ecfg, input string name);
      @(negedge clk);
      sample_valid = v;
      temperature  = t;
      cfg_we       = we;
      cfg_low      = lo;
      cfg_high     = hi;
      alarm_clear  = clr;
      @(posedge clk);
      exp_q.push_back({es, el, eh, est, ecfg});
      name_q.push_back(name);
   endtask

   task automatic smp(input logic [7:0] t, input logic [2:0] es, input bit el,
                      input bit eh, input bit est, input string name);
      step(1'b1, t, 1'b0, 8'd0, 8'd0, 1'b0, es, el, eh, est, 1'b0, name);
   endtask

   task automatic idle_inputs();
      @(negedge clk);
      sample_valid = 1'b0;
      cfg_we       = 1'b0;
      alarm_clear  = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("reset_state", {mon_state, low_abn, high_abn, alarm_sticky, cfg_error}, 7'd0);
      rst_n = 1'b1;

      // Normal samples inside the 35..39 window
      smp(8'd37, SN, 0, 0, 0, "t1_37a");
      smp(8'd37, SN, 0, 0, 0, "t1_37b");
      // Low excursion with debounce and hysteretic exit
      smp(8'd30, SPL, 0, 0, 0, "t2_30a");
      smp(8'd30, SPL, 0, 0, 0, "t2_30b");
      smp(8'd30, SL,  1, 0, 1, "t2_30c_low");
      smp(8'd35, SL,  1, 0, 1, "t2_35_hyst_hold");
      smp(8'd36, SN,  0, 0, 1, "t2_36_exit");
      // Interrupted high excursion then a real one
      smp(8'd45, SPH, 0, 0, 1, "t3_45a");
      smp(8'd45, SPH, 0, 0, 1, "t3_45b");
      smp(8'd37, SN,  0, 0, 1, "t3_37_reset_cnt");
      smp(8'd45, SPH, 0, 0, 1, "t3_45c");
      smp(8'd45, SPH, 0, 0, 1, "t3_45d");
      smp(8'd45, SH,  0, 1, 1, "t3_45e_high");
      smp(8'd38, SN,  0, 0, 1, "t3_38_exit");
      // LOW straight into a high excursion
      smp(8'd30, SPL, 0, 0, 1, "t4_30a");
      smp(8'd30, SPL, 0, 0, 1, "t4_30b");
      smp(8'd30, SL,  1, 0, 1, "t4_30c_low");
      smp(8'd50, SPH, 0, 0, 1, "t4_50a");
      smp(8'd50, SPH, 0, 0, 1, "t4_50b");
      smp(8'd50, SH,  0, 1, 1, "t4_50c_high");
      step(0, 8'd5, 0, 0, 0, 0, SH, 0, 1, 1, 0, "t4_novalid_hold");
      step(0, 8'd0, 0, 0, 0, 1, SH, 0, 1, 0, 0, "t4_clear_sticky");
      // Config rejection and acceptance
      step(0, 8'd0, 1, 8'd20, 8'd10, 0, SH, 0, 1, 0, 1, "t5_cfg_reject");
      step(0, 8'd0, 0, 0, 0, 0, SH, 0, 1, 0, 0, "t5_cfgerr_pulse_end");
      smp(8'd40, SH,  0, 1, 0, "t5_40_high_hold");
      smp(8'd38, SN,  0, 0, 0, "t5_38_old_high_thr");
      smp(8'd34, SPL, 0, 0, 0, "t5_34_old_low_thr");
      step(1, 8'd5, 1, 8'd10, 8'd60, 0, SN, 0, 0, 0, 0, "t5_cfg_accept_drop_sample");
      smp(8'd5,  SPL, 0, 0, 0, "t5_5_new_low_thr");
      smp(8'd62, SPH, 0, 0, 0, "t5_62a");
      smp(8'd62, SPH, 0, 0, 0, "t5_62b");
      step(1, 8'd62, 0, 0, 0, 1, SH, 0, 1, 1, 0, "t6_entry_beats_clear");
      step(0, 8'd0,  0, 0, 0, 1, SH, 0, 1, 0, 0, "t6_clear_next");
      step(0, 8'd0,  1, 8'd100, 8'd100, 0, SH, 0, 1, 0, 1, "t6_cfg_equal_reject");
      step(1, 8'd5,  1, 8'd10, 8'd60, 0, SN, 0, 0, 0, 0, "t6_cfg_reload");
      smp(8'd5, SPL, 0, 0, 0, "t6_5a");
      smp(8'd5, SPL, 0, 0, 0, "t6_5b");

      // Asynchronous reset mid-debounce, away from the clock edge
      idle_inputs();
      #1 rst_n = 1'b0;
      #1 check("t6_async_reset", {mon_state, low_abn, high_abn, alarm_sticky, cfg_error}, 7'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // Defaults restored and counter cleared: 30 is low again, three needed
      smp(8'd30, SPL, 0, 0, 0, "t6_30a_default_thr");
      smp(8'd30, SPL, 0, 0, 0, "t6_30b");
      smp(8'd30, SL,  1, 0, 1, "t6_30c_low");
      // Saturation at the top of the range
      step(0, 8'd0, 1, 8'd200, 8'd255, 0, SN, 0, 0, 1, 0, "t7_cfg_200_255");
      smp(8'd255, SN,  0, 0, 1, "t7_255a_not_above");
      smp(8'd255, SN,  0, 0, 1, "t7_255b_not_above");
      smp(8'd199, SPL, 0, 0, 1, "t7_199_below");
      idle_inputs();

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
